// File: rtl/rr_priority_arbiter_4_if.sv
`default_nettype none
// ============================================================================
// Module   : rr_priority_arbiter_4_if
// Brief    : Request/grant bundle between four masters and the arbiter.
// Revision : 1.0 - initial release
// ============================================================================
interface rr_priority_arbiter_4_if;
  logic [3:0] req;
  logic       rr_en;
  logic [3:0] gnt;
  logic [1:0] gnt_id;
  logic       gnt_valid;

  modport master (
    output req,
    output rr_en,
    input  gnt,
    input  gnt_id,
    input  gnt_valid
  );

  modport slave (
    input  req,
    input  rr_en,
    output gnt,
    output gnt_id,
    output gnt_valid
  );
endinterface
`default_nettype wire

// File: rtl/rr_priority_arbiter_4.sv
`default_nettype none
// ============================================================================
// Module   : rr_priority_arbiter_4
// Brief    : 4-requester fixed-priority / round-robin arbiter with grant hold
//            until release and a hold limit against starvation.
// Revision : 1.0 - initial release
// ============================================================================
module rr_priority_arbiter_4 #(
  parameter int unsigned MAX_HOLD = 8
) (
  input  wire                            clk,
  input  wire                            reset_n,
  rr_priority_arbiter_4_if.slave         bus
);

  localparam int unsigned c_cnt_w = 8;
  localparam logic [c_cnt_w-1:0] c_max_hold = c_cnt_w'(MAX_HOLD);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t             r_state;
  logic [3:0]         r_gnt;
  logic [1:0]         r_gnt_id;
  logic               r_gnt_valid;
  logic [1:0]         r_owner;
  logic [1:0]         r_last;
  logic [c_cnt_w-1:0] r_hold_cnt;

  logic [1:0]         w_win;
  logic [1:0]         w_idx;
  logic               w_found;
  logic               w_others;
  logic               w_release;

  // Round-robin search starts just below the last released owner and
  // wraps, so that owner is visited last.
  always_comb begin
    w_win   = 2'd0;
    w_idx   = 2'd0;
    w_found = 1'b0;
    if (!bus.rr_en) begin
      for (int i = 0; i < 4; i++) begin
        if (bus.req[i]) begin
          w_win = 2'(i);
        end
      end
    end else begin
      for (int k = 1; k <= 4; k++) begin
        w_idx = r_last - 2'(k);
        if (!w_found && bus.req[w_idx]) begin
          w_win   = w_idx;
          w_found = 1'b1;
        end
      end
    end
  end

  assign w_others  = |(bus.req & ~r_gnt);
  assign w_release = !bus.req[r_owner] ||
                     ((r_hold_cnt >= c_max_hold) && w_others);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= IDLE;
      r_gnt       <= 4'b0000;
      r_gnt_id    <= 2'd0;
      r_gnt_valid <= 1'b0;
      r_owner     <= 2'd0;
      r_last      <= 2'd0;
      r_hold_cnt  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (|bus.req) begin
            r_state     <= GRANT;
            r_gnt       <= 4'b0001 << w_win;
            r_gnt_id    <= w_win;
            r_gnt_valid <= 1'b1;
            r_owner     <= w_win;
            r_hold_cnt  <= c_cnt_w'(1);
          end
        end
        GRANT: begin
          // A release edge only clears; the next winner is picked one edge later.
          if (w_release) begin
            r_state     <= IDLE;
            r_gnt       <= 4'b0000;
            r_gnt_id    <= 2'd0;
            r_gnt_valid <= 1'b0;
            r_last      <= r_owner;
            r_hold_cnt  <= '0;
          end else if (r_hold_cnt < c_max_hold) begin
            r_hold_cnt  <= r_hold_cnt + c_cnt_w'(1);
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign bus.gnt       = r_gnt;
  assign bus.gnt_id    = r_gnt_id;
  assign bus.gnt_valid = r_gnt_valid;

endmodule
`default_nettype wire

// File: tb/tb_rr_priority_arbiter_4.sv
`default_nettype none
// ============================================================================
// Module   : tb_rr_priority_arbiter_4
// Brief    : Directed + random bench for two arbiter instances (hold limit 2
//            and 8) against a behavioural owner/hold/last model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rr_priority_arbiter_4;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [3:0] req_drv;
  logic       rr_drv;

  int errors = 0;
  int checks = 0;

  int m_owner [2];
  int m_held  [2];
  int m_last  [2];

  always #5 clk = ~clk;

  rr_priority_arbiter_4_if if_a ();
  rr_priority_arbiter_4_if if_b ();

  assign if_a.req   = req_drv;
  assign if_a.rr_en = rr_drv;
  assign if_b.req   = req_drv;
  assign if_b.rr_en = rr_drv;

  rr_priority_arbiter_4 #(.MAX_HOLD(2)) dut_a (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (if_a.slave)
  );

  rr_priority_arbiter_4 #(.MAX_HOLD(8)) dut_b (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (if_b.slave)
  );

  function automatic int lim(input int d);
    return (d == 0) ? 2 : 8;
  endfunction

  function automatic logic [3:0] exp_gnt(input int d);
    return (m_owner[d] < 0) ? 4'b0000 : 4'(1 << m_owner[d]);
  endfunction

  function automatic logic [3:0] exp_id(input int d);
    return (m_owner[d] < 0) ? 4'd0 : 4'(m_owner[d]);
  endfunction

  function automatic logic [3:0] exp_valid(input int d);
    return (m_owner[d] < 0) ? 4'd0 : 4'd1;
  endfunction

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_owner[d] = -1;
      m_held[d]  = 0;
      m_last[d]  = 0;
    end
  endtask

  // One clock edge of the arbitration rules, applied to each instance.
  task automatic model_step();
    for (int d = 0; d < 2; d++) begin
      if (m_owner[d] < 0) begin
        if (req_drv != 4'b0000) begin
          int w = -1;
          if (!rr_drv) begin
            for (int i = 3; i >= 0; i--)
              if (w < 0 && req_drv[i]) w = i;
          end else begin
            for (int k = 1; k <= 4; k++) begin
              int idx = (m_last[d] - k + 8) % 4;
              if (w < 0 && req_drv[idx]) w = idx;
            end
          end
          m_owner[d] = w;
          m_held[d]  = 1;
        end
      end else begin
        int others = 0;
        for (int i = 0; i < 4; i++)
          if (i != m_owner[d] && req_drv[i]) others++;
        if (!req_drv[m_owner[d]] || (m_held[d] >= lim(d) && others > 0)) begin
          m_last[d]  = m_owner[d];
          m_owner[d] = -1;
          m_held[d]  = 0;
        end else if (m_held[d] < lim(d)) begin
          m_held[d]++;
        end
      end
    end
  endtask

  task automatic compare_all(input string tag);
    chk({tag, "_a_gnt"},   if_a.gnt,                exp_gnt(0));
    chk({tag, "_a_id"},    {2'b00, if_a.gnt_id},    exp_id(0));
    chk({tag, "_a_valid"}, {3'b000, if_a.gnt_valid}, exp_valid(0));
    chk({tag, "_b_gnt"},   if_b.gnt,                exp_gnt(1));
    chk({tag, "_b_id"},    {2'b00, if_b.gnt_id},    exp_id(1));
    chk({tag, "_b_valid"}, {3'b000, if_b.gnt_valid}, exp_valid(1));
  endtask

  task automatic step(input logic [3:0] r, input logic rr, input string tag);
    req_drv = r;
    rr_drv  = rr;
    @(posedge clk);
    model_step();
    #1;
    compare_all(tag);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    #1;
    model_reset();
    compare_all("rst");
    @(posedge clk);
    #1;
    compare_all("rst_hold");
    reset_n = 1'b1;
  endtask

  task automatic pulse_reset(input string tag);
    #3;
    reset_n = 1'b0;
    #1;
    model_reset();
    compare_all(tag);
    #1;
    reset_n = 1'b1;
  endtask

  initial begin
    int         exp_rot [5] = '{3, 2, 1, 0, 3};
    int         rot_ids [$];
    logic       prev_valid;
    logic [3:0] cnt;
    logic [3:0] rq;
    logic       rr;

    reset_n = 1'b1;
    req_drv = 4'b1111;
    rr_drv  = 1'b0;
    model_reset();
    #2;
    reset_n = 1'b0;
    #1;
    compare_all("reset");
    @(posedge clk); #1; compare_all("reset_c1");
    @(posedge clk); #1; compare_all("reset_c2");
    req_drv = 4'b0000;
    reset_n = 1'b1;
    step(4'b0000, 1'b0, "idle0");
    step(4'b0000, 1'b0, "idle1");

    // Fixed priority
    step(4'b0101, 1'b0, "fix_grant");
    chk("fix_id2", {2'b00, if_a.gnt_id}, 4'd2);
    step(4'b0101, 1'b0, "fix_hold");
    step(4'b0001, 1'b0, "fix_rel");
    chk("fix_bubble", if_a.gnt, 4'b0000);
    step(4'b0001, 1'b0, "fix_g0");
    chk("fix_id0", if_a.gnt, 4'b0001);
    step(4'b0000, 1'b0, "fix_rel0");
    step(4'b0000, 1'b0, "fix_idle");
    step(4'b1001, 1'b0, "fix_g3");
    chk("fix_id3", {2'b00, if_b.gnt_id}, 4'd3);

    // Round-robin rotation from last=0 on the hold-limit-2 instance
    do_reset();
    prev_valid = 1'b0;
    for (int i = 0; i < 15; i++) begin
      step(4'b1111, 1'b1, "rot");
      if (if_a.gnt_valid && !prev_valid) rot_ids.push_back(int'(if_a.gnt_id));
      prev_valid = if_a.gnt_valid;
    end
    chk("rot_count", 4'(rot_ids.size()), 4'd5);
    for (int i = 0; i < 5; i++) begin
      if (i < rot_ids.size()) chk("rot_seq", 4'(rot_ids[i]), 4'(exp_rot[i]));
    end

    // Hold without competition, then forced release
    do_reset();
    cnt = 4'd0;
    for (int i = 0; i < 10; i++) begin
      step(4'b0010, 1'b0, "hold");
      if (if_a.gnt == 4'b0010) cnt++;
    end
    chk("hold_cycles", cnt, 4'd10);
    step(4'b1010, 1'b0, "hold_rel");
    chk("hold_rel_valid", {3'b000, if_a.gnt_valid}, 4'd0);
    step(4'b1010, 1'b0, "hold_next");
    chk("hold_next_id", {2'b00, if_a.gnt_id}, 4'd3);

    // Normal release before the limit on the hold-limit-8 instance
    do_reset();
    cnt = 4'd0;
    for (int i = 0; i < 6; i++) begin
      step((i < 3) ? 4'b1000 : 4'b0000, 1'b0, "norm");
      if (if_b.gnt == 4'b1000) cnt++;
    end
    chk("norm_cycles", cnt, 4'd3);

    // Reset in the middle of a grant
    do_reset();
    step(4'b0100, 1'b0, "mid_g");
    step(4'b0100, 1'b0, "mid_h");
    pulse_reset("mid_rst");
    chk("mid_rst_gnt", if_a.gnt, 4'b0000);
    step(4'b1111, 1'b1, "mid_after");
    chk("mid_after_id", {2'b00, if_a.gnt_id}, 4'd3);

    // Random traffic with sticky request lines
    rq = 4'($urandom_range(0, 15));
    rr = 1'b1;
    for (int i = 0; i < 400; i++) begin
      for (int b = 0; b < 4; b++)
        if ($urandom_range(0, 4) == 0) rq[b] = ~rq[b];
      if ($urandom_range(0, 19) == 0) rr = ~rr;
      step(rq, rr, "rand");
      if ($urandom_range(0, 149) == 0) pulse_reset("rand_rst");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/rr_priority_arbiter_4.md
# rr_priority_arbiter_4

Sequential 4-requester arbiter that shares one downstream resource between up to four masters, using the 4-to-2 priority-encoding convention (higher index wins, 2-bit id plus valid flag). It runs in fixed-priority or round-robin mode. A grant is held until the owner releases it, and a hold limit prevents one master from starving the others. The arbiter sits between the request lines of the masters and the select input of the shared datapath mux.

## Interface
- MAX_HOLD, 8, maximum granted cycles before a forced release when other requests are pending (legal range 1..255)
- clk  input  1  rising-edge clock
- reset_n  input  1  asynchronous active-low reset
- req  input  4  request lines; bit i = master i; level-held while it wants or uses the resource
- rr_en  input  1  1 = round-robin, 0 = fixed priority (bit 3 highest); sampled only at arbitration
- gnt  output  4  one-hot grant, registered; all-zero when no grant
- gnt_id  output  2  encoded index of the granted master; 0 when gnt_valid=0
- gnt_valid  output  1  1 while a grant is active (equals OR of gnt)

## Operation
- Two states:
  - IDLE: no grant.
  - GRANT: one owner holds the resource.
- IDLE:
  - If req==0, stay in IDLE.
  - Otherwise, at the clock edge, pick a winner from req. Load gnt, gnt_id, gnt_valid=1, owner=winner and hold_cnt=1, then go to GRANT.
- Winner selection, fixed mode (rr_en=0): the highest set bit of req. This is the same priority as the 4-to-2 encoder.
- Winner selection, round-robin mode (rr_en=1):
  - Search order is last-1, last-2, last-3, last, all mod 4. "last" is the id of the most recently released owner.
  - The first set bit in that order wins.
  - Reset value of last is 0, so the first round-robin search order is 3,2,1,0.
- GRANT, normal release: if req[owner]==0, go to IDLE at the next edge.
  - gnt clears to 0, gnt_valid to 0 and gnt_id to 0.
  - last takes owner.
- GRANT, forced release: if hold_cnt>=MAX_HOLD and any other req bit is set, release the same way even though req[owner] is still 1.
- GRANT, otherwise: stay in GRANT. hold_cnt increments and saturates at MAX_HOLD.
- If req[owner] stays 1 and no other master is requesting, the grant is held indefinitely.
- A forced-released master whose req is still high competes at the next arbitration:
  - In round-robin mode it has the lowest priority there.
  - In fixed mode it may win again if it is the highest set bit.
- last updates on every release in both modes. Switching rr_en therefore takes effect at the next arbitration with no extra state.
- req changes during GRANT have no effect on gnt except through the two release conditions.

## Timing
- All outputs are registered; there is no combinational path from req to gnt.
- Reset values (asynchronous, immediate on reset_n low):
  - state=IDLE, gnt=0000, gnt_id=0, gnt_valid=0
  - last=0, hold_cnt=0
- Latency:
  - A req asserted before edge N with the arbiter in IDLE gives gnt at edge N, visible in cycle N..N+1.
  - A release condition seen at edge M clears gnt at edge M.
- Arbitration always inserts one idle (bubble) cycle between consecutive grants. The minimum period between two grants is 2 cycles, so back-to-back owners never overlap.
- An owner with MAX_HOLD=k and continuous competition holds the grant for exactly k cycles (gnt high for k edges), followed by 1 bubble cycle.
- Simultaneous release and new requests: the release edge only clears. The new winner is chosen at the following edge from req sampled then.
- Reset mid-grant drops gnt asynchronously. After reset_n deasserts, arbitration restarts from IDLE with last=0.
- Invariant: gnt is one-hot or zero at all times, and gnt_valid==|gnt.

## Test plan
- Reset/idle: reset_n=0 for 2 cycles with req=1111 -> gnt=0000, gnt_id=0, gnt_valid=0. Release reset with req=0000 -> outputs stay 0.
- Fixed priority: rr_en=0, req=0101 held -> at edge 1, gnt=0100, gnt_id=2, valid=1. Drop req[2] -> bubble cycle, then gnt=0001, gnt_id=0. req=1001 -> gnt_id=3.
- Round-robin rotation: rr_en=1, req=1111, MAX_HOLD=2 -> grant sequence of ids 3,2,1,0,3. Each grant lasts 2 cycles followed by 1 bubble.
- Hold without competition: MAX_HOLD=2, req=0010 for 10 cycles -> gnt=0010 continuously with no release. Assert req[3] -> release at the next edge, then gnt_id=3 (fixed mode).
- Normal release before limit: MAX_HOLD=8, req=1000 for 3 cycles then 0000 -> gnt high exactly 3 cycles, then gnt=0000 and valid=0.
- Reset mid-grant: gnt=0100 active, pulse reset_n low between edges -> gnt=0000 immediately. After release, req=1111 with rr_en=1 -> gnt_id=3 (last reset to 0).
